// File: rtl/round_scheduler.sv
// round_scheduler
//   Game-round sequencer. Divides the system clock down to a game tick and
//   runs the round FSM IDLE -> COUNTDOWN -> PLAY <-> PAUSE -> OVER. While in
//   PLAY it requests spawns at an interval that shrinks as the round goes on.
// Ports
//   clk            in   system clock
//   reset          in   synchronous, active-high
//   start          in   1-cycle pulse, starts a round from IDLE or OVER
//   pause          in   1-cycle pulse, toggles PLAY <-> PAUSE
//   fail           in   1-cycle pulse, ends the round from PLAY
//   state          out  0 IDLE, 1 COUNTDOWN, 2 PLAY, 3 PAUSE, 4 OVER
//   tick           out  1-cycle game tick (COUNTDOWN/PLAY only)
//   countdown      out  ticks left in COUNTDOWN
//   time_left      out  ticks left in the round
//   elapsed        out  PLAY ticks since round start, saturating
//   spawn_interval out  current spawn interval in ticks
//   spawn          out  1-cycle spawn request
//   round_done     out  1-cycle pulse on entry to OVER
module round_scheduler #(
  parameter int TICK_DIV        = 5000000,
  parameter int COUNTDOWN_TICKS = 30,
  parameter int ROUND_TICKS     = 600,
  parameter int SPAWN_START     = 20,
  parameter int SPAWN_MIN       = 5,
  parameter int RAMP_TICKS      = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        pause,
  input  logic        fail,
  output logic [2:0]  state,
  output logic        tick,
  output logic [7:0]  countdown,
  output logic [15:0] time_left,
  output logic [19:0] elapsed,
  output logic [7:0]  spawn_interval,
  output logic        spawn,
  output logic        round_done
);

  localparam int DIV_W  = $clog2(TICK_DIV);
  localparam int RAMP_W = $clog2(RAMP_TICKS + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_TICKS - 1);
  localparam logic [7:0]        SI_START  = 8'(SPAWN_START);
  localparam logic [7:0]        SI_MIN    = 8'(SPAWN_MIN);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COUNTDOWN = 3'd1,
    PLAY      = 3'd2,
    PAUSE     = 3'd3,
    OVER      = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [RAMP_W-1:0] ramp_cnt_q, ramp_cnt_d;
  logic [7:0]        countdown_q, countdown_d;
  logic [15:0]       time_left_q, time_left_d;
  logic [19:0]       elapsed_q, elapsed_d;
  logic [7:0]        spawn_interval_q, spawn_interval_d;
  logic [7:0]        spawn_cnt_q, spawn_cnt_d;
  logic              tick_q, tick_d;
  logic              spawn_q, spawn_d;
  logic              round_done_q, round_done_d;
  logic              tick_edge_s;
  logic [7:0]        si_next_s;

  // Next-state and next-counter computation for the round sequencer.
  always_comb begin
    state_d          = state_q;
    div_cnt_d        = div_cnt_q;
    ramp_cnt_d       = ramp_cnt_q;
    countdown_d      = countdown_q;
    time_left_d      = time_left_q;
    elapsed_d        = elapsed_q;
    spawn_interval_d = spawn_interval_q;
    spawn_cnt_d      = spawn_cnt_q;
    tick_d           = 1'b0;
    spawn_d          = 1'b0;
    round_done_d     = 1'b0;
    si_next_s        = spawn_interval_q;
    tick_edge_s      = ((state_q == COUNTDOWN) || (state_q == PLAY)) && (div_cnt_q == DIV_LAST);

    case (state_q)
      IDLE, OVER: begin
        div_cnt_d = {DIV_W{1'b0}};
        if (start) begin
          state_d     = COUNTDOWN;
          countdown_d = 8'(COUNTDOWN_TICKS);
        end else begin
          state_d = state_q;
        end
      end

      COUNTDOWN: begin
        if (tick_edge_s) begin
          div_cnt_d = {DIV_W{1'b0}};
          tick_d    = 1'b1;
          if (countdown_q == 8'd1) begin
            state_d          = PLAY;
            countdown_d      = 8'd0;
            time_left_d      = 16'(ROUND_TICKS);
            elapsed_d        = 20'd0;
            spawn_interval_d = SI_START;
            spawn_cnt_d      = SI_START;
            ramp_cnt_d       = {RAMP_W{1'b0}};
          end else begin
            countdown_d = countdown_q - 8'd1;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      PLAY: begin
        // fail outranks pause, and both outrank a coincident tick; a tick
        // deferred by pause fires right after resume because the phase is kept.
        if (fail) begin
          state_d      = OVER;
          round_done_d = 1'b1;
          div_cnt_d    = {DIV_W{1'b0}};
        end else if (pause) begin
          state_d = PAUSE;
        end else if (tick_edge_s) begin
          div_cnt_d = {DIV_W{1'b0}};
          tick_d    = 1'b1;
          elapsed_d = (elapsed_q == 20'hFFFFF) ? elapsed_q : (elapsed_q + 20'd1);
          if (ramp_cnt_q == RAMP_LAST) begin
            ramp_cnt_d = {RAMP_W{1'b0}};
            si_next_s  = (spawn_interval_q > SI_MIN) ? (spawn_interval_q - 8'd1) : SI_MIN;
          end else begin
            ramp_cnt_d = ramp_cnt_q + RAMP_W'(1);
            si_next_s  = spawn_interval_q;
          end
          spawn_interval_d = si_next_s;
          if (time_left_q == 16'd1) begin
            // Last tick of the round: finish without a spawn.
            time_left_d  = 16'd0;
            state_d      = OVER;
            round_done_d = 1'b1;
          end else begin
            time_left_d = time_left_q - 16'd1;
            if (spawn_cnt_q == 8'd1) begin
              spawn_d     = 1'b1;
              spawn_cnt_d = si_next_s;
            end else begin
              spawn_cnt_d = spawn_cnt_q - 8'd1;
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      PAUSE: begin
        if (pause) begin
          state_d = PLAY;
        end else begin
          state_d = state_q;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      div_cnt_q        <= {DIV_W{1'b0}};
      ramp_cnt_q       <= {RAMP_W{1'b0}};
      countdown_q      <= 8'd0;
      time_left_q      <= 16'd0;
      elapsed_q        <= 20'd0;
      spawn_interval_q <= SI_START;
      spawn_cnt_q      <= 8'd0;
      tick_q           <= 1'b0;
      spawn_q          <= 1'b0;
      round_done_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      div_cnt_q        <= div_cnt_d;
      ramp_cnt_q       <= ramp_cnt_d;
      countdown_q      <= countdown_d;
      time_left_q      <= time_left_d;
      elapsed_q        <= elapsed_d;
      spawn_interval_q <= spawn_interval_d;
      spawn_cnt_q      <= spawn_cnt_d;
      tick_q           <= tick_d;
      spawn_q          <= spawn_d;
      round_done_q     <= round_done_d;
    end
  end

  assign state          = state_q;
  assign tick           = tick_q;
  assign countdown      = countdown_q;
  assign time_left      = time_left_q;
  assign elapsed        = elapsed_q;
  assign spawn_interval = spawn_interval_q;
  assign spawn          = spawn_q;
  assign round_done     = round_done_q;

endmodule

// File: tb/tb_round_scheduler.sv
// tb_round_scheduler
//   Directed round scenarios followed by random pulses on start/pause/fail/
//   reset. Every cycle the outputs are compared with a reference model that
//   tracks the round by PLAY tick number n: time_left = ROUND-n, elapsed = n,
//   interval = max(START - n/RAMP, MIN), next spawn at n + interval(n).
module tb_round_scheduler;

  localparam int TD  = 4;
  localparam int CDT = 3;
  localparam int RT  = 20;
  localparam int SS  = 4;
  localparam int SM  = 2;
  localparam int RP  = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        pause = 1'b0;
  logic        fail = 1'b0;
  logic [2:0]  state;
  logic        tick;
  logic [7:0]  countdown;
  logic [15:0] time_left;
  logic [19:0] elapsed;
  logic [7:0]  spawn_interval;
  logic        spawn;
  logic        round_done;

  int total = 0;
  int bad = 0;

  // reference model state
  int m_state = 0;
  int m_phase = 0;
  int m_cd = 0;
  int m_n = 0;
  int m_next = 0;
  int m_played = 0;
  int m_tick = 0;
  int m_spawn = 0;
  int m_done = 0;

  round_scheduler #(
    .TICK_DIV(TD), .COUNTDOWN_TICKS(CDT), .ROUND_TICKS(RT),
    .SPAWN_START(SS), .SPAWN_MIN(SM), .RAMP_TICKS(RP)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .fail(fail),
    .state(state), .tick(tick), .countdown(countdown), .time_left(time_left),
    .elapsed(elapsed), .spawn_interval(spawn_interval), .spawn(spawn),
    .round_done(round_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int si_of(input int n);
    int v;
    v = SS - n / RP;
    return (v < SM) ? SM : v;
  endfunction

  // Advance the model by one clock edge given the inputs seen at that edge.
  task automatic model_step(input logic r, input logic st, input logic pa, input logic fa);
    m_tick = 0; m_spawn = 0; m_done = 0;
    if (r) begin
      m_state = 0; m_phase = 0; m_cd = 0; m_n = 0; m_played = 0;
    end else begin
      case (m_state)
        0, 4: begin
          m_phase = 0;
          if (st) begin m_state = 1; m_cd = CDT; end
        end
        1: begin
          if (m_phase == TD - 1) begin
            m_phase = 0; m_tick = 1; m_cd--;
            if (m_cd == 0) begin
              m_state = 2; m_n = 0; m_played = 1; m_next = SS;
            end
          end else m_phase++;
        end
        2: begin
          if (fa) begin
            m_state = 4; m_done = 1; m_phase = 0;
          end else if (pa) begin
            m_state = 3;
          end else if (m_phase == TD - 1) begin
            m_phase = 0; m_tick = 1; m_n++;
            if (m_n == RT) begin
              m_state = 4; m_done = 1;
            end else if (m_n == m_next) begin
              m_spawn = 1; m_next = m_n + si_of(m_n);
            end
          end else m_phase++;
        end
        3: if (pa) m_state = 2;
        default: m_state = 0;
      endcase
    end
  endtask

  task automatic cycle(input logic r, input logic st, input logic pa, input logic fa);
    reset = r; start = st; pause = pa; fail = fa;
    @(posedge clk);
    model_step(r, st, pa, fa);
    #1;
    check("state", state, m_state);
    check("tick", tick, m_tick);
    check("countdown", countdown, m_cd);
    check("time_left", time_left, m_played ? RT - m_n : 0);
    check("elapsed", elapsed, m_played ? m_n : 0);
    check("spawn_interval", spawn_interval, m_played ? si_of(m_n) : SS);
    check("spawn", spawn, m_spawn);
    check("round_done", round_done, m_done);
    reset = 1'b0; start = 1'b0; pause = 1'b0; fail = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int tk;
    int w;
    logic [31:0] mask;
    logic [31:0] exp_mask;

    // reset
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_state", state, 0);
    check("rst_si", spawn_interval, 4);
    check("rst_tl", time_left, 0);

    // 1: countdown 3,2,1 every 4 cycles, PLAY after 12
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("cd_entry", countdown, 3);
    run(4);
    check("cd_t1", countdown, 2);
    run(4);
    check("cd_t2", countdown, 1);
    run(4);
    check("play_state", state, 2);
    check("play_tl", time_left, 20);
    check("play_si", spawn_interval, 4);

    // 2: uninterrupted round
    tk = 0; mask = 32'd0;
    for (int i = 0; i < 80; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      if (tick) begin
        tk++;
        if (tk == 5) check("si_t5", spawn_interval, 3);
        if (tk == 10) check("si_t10", spawn_interval, 2);
      end
      if (spawn) mask[tk] = 1'b1;
    end
    exp_mask = 32'h000AA910;
    check("spawn_ticks", mask, exp_mask);
    check("over_state", state, 4);
    check("over_done", round_done, 1);
    check("over_tl", time_left, 0);
    check("over_el", elapsed, 20);

    // 3: pause/resume keeps tick phase
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    run(12 + 24);
    check("t6_tl", time_left, 14);
    run(2);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("paused", state, 3);
    tk = 0;
    for (int i = 0; i < 50; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      if (tick) tk++;
    end
    check("pause_noticks", tk, 0);
    check("pause_tl", time_left, 14);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    check("resumed", state, 2);
    w = 0;
    do begin
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      w++;
    end while (!tick && w < 10);
    check("resume_lat", w, 2);
    check("resume_tl", time_left, 13);

    // 4: fail coincident with tick 9
    run(7);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("fail_state", state, 4);
    check("fail_done", round_done, 1);
    check("fail_tick", tick, 0);
    check("fail_tl", time_left, 12);

    // 5: reset mid-PLAY
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    run(12 + 52);
    check("pre_rst_tl", time_left, 7);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("mid_rst_state", state, 0);
    check("mid_rst_tl", time_left, 0);
    check("mid_rst_el", elapsed, 0);
    check("mid_rst_si", spawn_interval, 4);

    // 6: ignored inputs during COUNTDOWN and PLAY
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    run(9);
    check("cd_ignore_state", state, 1);
    check("cd_ignore_cd", countdown, 1);
    run(1);
    check("cd_full", state, 2);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("play_start_ign", state, 2);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("fail_over", state, 4);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    check("restart_state", state, 1);
    check("restart_cd", countdown, 3);

    // random pulses against the model
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(499) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(39) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(29) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(199) == 0) ? 1'b1 : 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
